// File: rtl/t_switch_arbiter.sv
// Three-port (left/right/up) fat-tree switch node: address decode, per-output round-robin
// arbitration and one registered output stage per port. Optional misroute counter: TSW_ERR_CNT_EN.
module t_switch_arbiter #(
    parameter int num_leaves = 8,
    parameter int level      = 1,
    parameter int addr       = 0,
    parameter int payload_sz = 32,
    localparam int aw        = $clog2(num_leaves),
    localparam int fw        = aw + payload_sz
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          l_valid_i,
    input  logic [fw-1:0] l_data_i,
    output logic          l_ready_o,
    input  logic          r_valid_i,
    input  logic [fw-1:0] r_data_i,
    output logic          r_ready_o,
    input  logic          u_valid_i,
    input  logic [fw-1:0] u_data_i,
    output logic          u_ready_o,
    output logic          l_valid_o,
    output logic [fw-1:0] l_data_o,
    input  logic          l_ready_i,
    output logic          r_valid_o,
    output logic [fw-1:0] r_data_o,
    input  logic          r_ready_i,
    output logic          u_valid_o,
    output logic [fw-1:0] u_data_o,
    input  logic          u_ready_i
`ifdef TSW_ERR_CNT_EN
    ,
    output logic [7:0]    err_cnt_o
`endif
);

    typedef enum logic [1:0] {
        PORT_L = 2'd0,
        PORT_R = 2'd1,
        PORT_U = 2'd2
    } port_e;

    localparam int              sel_bit = (level < aw) ? aw - 1 - level : 0;
    localparam int              shamt   = aw - level;
    localparam logic [aw-1:0]   prefix  = aw'(addr);

    // Two legal sources per output, indexed by output port; source a is favored after reset.
    localparam int src_a [3] = '{1, 0, 0};
    localparam int src_b [3] = '{2, 2, 1};

    function automatic port_e decode(input logic [aw-1:0] dest);
        if (level == 0)
            return dest[aw-1] ? PORT_R : PORT_L;
        else if ((dest >> shamt) != prefix)
            return PORT_U;
        else
            return dest[sel_bit] ? PORT_R : PORT_L;
    endfunction

    logic [2:0]    in_valid;
    logic [2:0]    in_ready;
    logic [2:0]    out_ready;
    logic [2:0]    out_valid;
    logic [fw-1:0] in_data   [3];
    logic [fw-1:0] out_data  [3];

    assign in_valid   = {u_valid_i, r_valid_i, l_valid_i};
    assign out_ready  = {u_ready_i, r_ready_i, l_ready_i};
    assign in_data[0] = l_data_i;
    assign in_data[1] = r_data_i;
    assign in_data[2] = u_data_i;

    assign l_ready_o = in_ready[0];
    assign r_ready_o = in_ready[1];
    assign u_ready_o = in_ready[2];
    assign l_valid_o = out_valid[0];
    assign r_valid_o = out_valid[1];
    assign u_valid_o = out_valid[2];
    assign l_data_o  = out_data[0];
    assign r_data_o  = out_data[1];
    assign u_data_o  = out_data[2];

    port_e      route [3];
    logic [2:0] misroute;
    logic [2:0] fwd;

    // A flit bouncing back to its arrival port (or any up-flit at the root) is swallowed.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            route[i]    = decode(in_data[i][fw-1:payload_sz]);
            misroute[i] = in_valid[i] && ((int'(route[i]) == i) || (level == 0 && i == 2));
            fwd[i]      = in_valid[i] && !misroute[i];
        end
    end

    logic [2:0]    prio;
    logic [2:0]    can_accept;
    logic [2:0]    load;
    logic [2:0]    load_b;
    logic [fw-1:0] load_data [3];

    // NOTE: every signal driven here gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        logic req_a;
        logic req_b;
        logic gnt_a;
        logic gnt_b;
        in_ready   = misroute;
        can_accept = '0;
        load       = '0;
        load_b     = '0;
        for (int o = 0; o < 3; o++) begin
            req_a         = fwd[src_a[o]] && (int'(route[src_a[o]]) == o);
            req_b         = fwd[src_b[o]] && (int'(route[src_b[o]]) == o);
            gnt_b         = req_b && (!req_a || prio[o]);
            gnt_a         = req_a && !gnt_b;
            can_accept[o] = !out_valid[o] || out_ready[o];
            load[o]       = (gnt_a || gnt_b) && can_accept[o] && !(level == 0 && o == 2);
            load_b[o]     = gnt_b;
            load_data[o]  = gnt_b ? in_data[src_b[o]] : in_data[src_a[o]];
            if (load[o])
                in_ready[gnt_b ? src_b[o] : src_a[o]] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the data registers are reset too because downstream observes data_o = 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= '0;
            prio      <= '0;
            for (int o = 0; o < 3; o++)
                out_data[o] <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o]  <= load_data[o];
                    prio[o]      <= !load_b[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef TSW_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    always_comb begin
        err_inc = 2'(misroute[0]) + 2'(misroute[1]) + 2'(misroute[2]);
        err_sum = {1'b0, err_cnt} + 9'(err_inc);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= '0;
        else if (err_sum > 9'd255)
            err_cnt <= 8'hff;
        else
            err_cnt <= err_sum[7:0];
    end

    assign err_cnt_o = err_cnt;
`endif

endmodule

// File: tb/tb_t_switch_arbiter.sv
// Scoreboard bench for t_switch_arbiter: level-1 node (addr 0) plus a root instance.
module tb_t_switch_arbiter;

    localparam int FW = 35;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [2:0]    vin;
    logic [2:0]    rdy_i;
    logic [FW-1:0] din [3];
    wire  [2:0]    rdy_o;
    wire           l_valid_o, r_valid_o, u_valid_o;
    wire  [FW-1:0] l_data_o, r_data_o, u_data_o;

    logic [2:0]    vin1;
    logic [FW-1:0] din1 [3];
    wire  [2:0]    rdy1_o;
    wire           l_valid1, r_valid1, u_valid1;
    wire  [FW-1:0] l_data1, r_data1, u_data1;

`ifdef TSW_ERR_CNT_EN
    wire [7:0] err_cnt;
    wire [7:0] err_cnt1;
`endif

    t_switch_arbiter #(.num_leaves(8), .level(1), .addr(0), .payload_sz(32)) dut (
        .clk(clk), .reset_n(rst_n),
        .l_valid_i(vin[0]), .l_data_i(din[0]), .l_ready_o(rdy_o[0]),
        .r_valid_i(vin[1]), .r_data_i(din[1]), .r_ready_o(rdy_o[1]),
        .u_valid_i(vin[2]), .u_data_i(din[2]), .u_ready_o(rdy_o[2]),
        .l_valid_o(l_valid_o), .l_data_o(l_data_o), .l_ready_i(rdy_i[0]),
        .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_ready_i(rdy_i[1]),
        .u_valid_o(u_valid_o), .u_data_o(u_data_o), .u_ready_i(rdy_i[2])
`ifdef TSW_ERR_CNT_EN
        , .err_cnt_o(err_cnt)
`endif
    );

    t_switch_arbiter #(.num_leaves(8), .level(0), .addr(0), .payload_sz(32)) dut_root (
        .clk(clk), .reset_n(rst_n),
        .l_valid_i(vin1[0]), .l_data_i(din1[0]), .l_ready_o(rdy1_o[0]),
        .r_valid_i(vin1[1]), .r_data_i(din1[1]), .r_ready_o(rdy1_o[1]),
        .u_valid_i(vin1[2]), .u_data_i(din1[2]), .u_ready_o(rdy1_o[2]),
        .l_valid_o(l_valid1), .l_data_o(l_data1), .l_ready_i(1'b1),
        .r_valid_o(r_valid1), .r_data_o(r_data1), .r_ready_i(1'b1),
        .u_valid_o(u_valid1), .u_data_o(u_data1), .u_ready_i(1'b1)
`ifdef TSW_ERR_CNT_EN
        , .err_cnt_o(err_cnt1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [FW-1:0] q_l [$];
    logic [FW-1:0] q_r [$];
    logic [FW-1:0] q_u [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [2:0] dest, input logic [31:0] pl);
        return {dest, pl};
    endfunction

    task automatic push(input int o, input logic [FW-1:0] f);
        case (o)
            0: q_l.push_back(f);
            1: q_r.push_back(f);
            default: q_u.push_back(f);
        endcase
    endtask

    // Monitor: every output beat with valid && ready is consumed at the next edge.
    task automatic mon(input int o, input logic v, input logic r, input logic [FW-1:0] d);
        logic [FW-1:0] e;
        int sz;
        if (v && r) begin
            sz = (o == 0) ? q_l.size() : (o == 1) ? q_r.size() : q_u.size();
            if (sz == 0) begin
                check($sformatf("unexpected_flit_p%0d", o), v, 1'b0);
            end else begin
                case (o)
                    0: e = q_l.pop_front();
                    1: e = q_r.pop_front();
                    default: e = q_u.pop_front();
                endcase
                check($sformatf("out_data_p%0d", o), d, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon(0, l_valid_o, rdy_i[0], l_data_o);
            mon(1, r_valid_o, rdy_i[1], r_data_o);
            mon(2, u_valid_o, rdy_i[2], u_data_o);
        end
    end

    task automatic send(input int p, input logic [2:0] dest, input logic [31:0] pl,
                        input int exp_o, input bit do_push);
        logic [FW-1:0] f;
        int n;
        f = mk(dest, pl);
        n = 0;
        vin[p] = 1'b1;
        din[p] = f;
        @(negedge clk);
        while (!rdy_o[p] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_p%0d", p), rdy_o[p], 1'b1);
        if (rdy_o[p] && do_push)
            push(exp_o, f);
        @(posedge clk);
        #1;
        vin[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vin   = '0;
        vin1  = '0;
        rdy_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            din[i]  = '0;
            din1[i] = '0;
        end

        #1;
        check("rst_valid", {l_valid_o, r_valid_o, u_valid_o}, 3'b000);
        check("rst_l_data", l_data_o, '0);
        check("rst_r_data", r_data_o, '0);
        check("rst_u_data", u_data_o, '0);
        check("rst_root_valid", {l_valid1, r_valid1, u_valid1}, 3'b000);
`ifdef TSW_ERR_CNT_EN
        check("rst_err_cnt", err_cnt, 8'd0);
`endif
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Routing, one flit at a time, one-cycle latency.
        send(0, 3'b011, 32'hA000_0001, 1, 1'b1);
        @(negedge clk); check("lat_l_to_r", r_valid_o, 1'b1);
        @(posedge clk); #1;
        send(1, 3'b000, 32'hA000_0002, 0, 1'b1);
        @(negedge clk); check("lat_r_to_l", l_valid_o, 1'b1);
        @(posedge clk); #1;
        send(0, 3'b101, 32'hA000_0003, 2, 1'b1);
        @(negedge clk); check("lat_l_to_u", u_valid_o, 1'b1);
        @(posedge clk); #1;
        send(2, 3'b010, 32'hA000_0004, 1, 1'b1);
        @(negedge clk); check("lat_u_to_r", r_valid_o, 1'b1);

        // Contention on R output: L first out of reset, then strict alternation.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push(1, mk(3'b010, 32'hC0 + k));
            push(1, mk(3'b010, 32'hD0 + k));
        end
        fork
            begin
                for (int k = 0; k < 3; k++) send(0, 3'b010, 32'hC0 + k, 1, 1'b0);
            end
            begin
                for (int k = 0; k < 3; k++) send(2, 3'b010, 32'hD0 + k, 1, 1'b0);
            end
            begin
                @(posedge clk);
                repeat (6) begin
                    @(negedge clk);
                    check("r_valid_streak", r_valid_o, 1'b1);
                end
            end
        join

        // Backpressure on U output.
        do_reset();
        rdy_i[2] = 1'b0;
        push(2, mk(3'b100, 32'hB0));
        push(2, mk(3'b110, 32'hB1));
        push(2, mk(3'b101, 32'hB2));
        fork
            begin
                send(0, 3'b100, 32'hB0, 2, 1'b0);
                send(0, 3'b101, 32'hB2, 2, 1'b0);
            end
            send(1, 3'b110, 32'hB1, 2, 1'b0);
            begin
                @(posedge clk);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_u_data_stable", u_data_o, mk(3'b100, 32'hB0));
                    check("bp_l_ready", rdy_o[0], 1'b0);
                    check("bp_r_ready", rdy_o[1], 1'b0);
                end
                @(posedge clk);
                #1;
                rdy_i[2] = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_drain_valid", u_valid_o, 1'b1);
                end
                @(negedge clk);
                check("bp_drained", u_valid_o, 1'b0);
            end
        join

        // Misroutes: accepted together, dropped, counted.
        @(posedge clk); #1;
        vin[0] = 1'b1; din[0] = mk(3'b001, 32'hEE01);
        vin[2] = 1'b1; din[2] = mk(3'b110, 32'hEE02);
        @(negedge clk);
        check("mis_l_ready", rdy_o[0], 1'b1);
        check("mis_u_ready", rdy_o[2], 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("mis_no_valid", {l_valid_o, r_valid_o, u_valid_o}, 3'b000);
`ifdef TSW_ERR_CNT_EN
        check("mis_err_cnt_2", err_cnt, 8'd2);
`endif
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("mis_no_valid_long", {l_valid_o, r_valid_o, u_valid_o}, 3'b000);
`ifdef TSW_ERR_CNT_EN
        check("mis_err_cnt_sat", err_cnt, 8'd255);
        @(negedge clk);
        check("mis_err_cnt_hold", err_cnt, 8'd255);
`endif
        @(posedge clk); #1;
        vin = '0;

        // Async reset mid-cycle; R output must favor L again afterwards.
        send(0, 3'b011, 32'hF000_0001, 1, 1'b1);
        rdy_i[0] = 1'b0;
        send(1, 3'b000, 32'hF000_0002, 0, 1'b0);
        @(negedge clk);
        check("pre_rst_l_valid", l_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_l_valid", l_valid_o, 1'b0);
        check("async_rst_l_data", l_data_o, '0);
`ifdef TSW_ERR_CNT_EN
        check("async_rst_err_cnt", err_cnt, 8'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_i[0] = 1'b1;
        push(1, mk(3'b010, 32'hE0));
        push(1, mk(3'b010, 32'hE1));
        fork
            send(0, 3'b010, 32'hE0, 1, 1'b0);
            send(2, 3'b010, 32'hE1, 1, 1'b0);
        join

        // Root node: up-input flits are dropped, L reaches R on MSB=1.
        @(posedge clk); #1;
        vin1[2] = 1'b1; din1[2] = mk(3'b100, 32'h7700);
        @(negedge clk);
        check("root_u_ready", rdy1_o[2], 1'b1);
        @(posedge clk); #1;
        vin1[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("root_no_valid", {l_valid1, r_valid1, u_valid1}, 3'b000);
        end
        @(posedge clk); #1;
        vin1[0] = 1'b1; din1[0] = mk(3'b111, 32'h7701);
        @(negedge clk);
        check("root_l_ready", rdy1_o[0], 1'b1);
        @(posedge clk); #1;
        vin1[0] = 1'b0;
        @(negedge clk);
        check("root_r_valid", r_valid1, 1'b1);
        check("root_r_data", r_data1, mk(3'b111, 32'h7701));
        check("root_u_valid", u_valid1, 1'b0);

        repeat (4) @(posedge clk);
        check("q_l_empty", q_l.size(), 0);
        check("q_r_empty", q_r.size(), 0);
        check("q_u_empty", q_u.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t_switch_arbiter.md
# t_switch_arbiter

Three-port (left, right, up) tree switch node for the butterfly fat-tree NoC: routes single-flit packets from each input port toward the correct child or parent and arbitrates contention for each output port. It decodes destination addresses internally, grants each output round-robin between its two possible sources, and drives one registered output stage per port with valid/ready handshakes. One instance sits at each tree node. The node's tree position is set by `level` and `addr`.

## Interface
Parameters:
- `num_leaves`, 8: number of leaf PEs; address width `aw = $clog2(num_leaves)`.
- `level`, 1: depth of this node; 0 = root.
- `addr`, 0: `level`-bit prefix of this node's subtree. Unused when `level == 0`.
- `payload_sz`, 32: payload bits per flit. Flit width `fw = aw + payload_sz`, with the destination in `[fw-1:payload_sz]`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `l_valid_i`, `r_valid_i`, `u_valid_i`, in, 1: input flit valid.
- `l_data_i`, `r_data_i`, `u_data_i`, in, fw: input flit.
- `l_ready_o`, `r_ready_o`, `u_ready_o`, out, 1: input accepted this cycle (combinational).
- `l_valid_o`, `r_valid_o`, `u_valid_o`, out, 1: output flit valid (registered).
- `l_data_o`, `r_data_o`, `u_data_o`, out, fw: output flit (registered).
- `l_ready_i`, `r_ready_i`, `u_ready_i`, in, 1: downstream accepts.
- `err_cnt_o`, out, 8: misroute counter. Present only with `TSW_ERR_CNT_EN`.

## Operation
Routing decode, per input:
- Invalid input: no request.
- `level == 0`: the destination MSB selects the output; 0 → L, 1 → R.
- `level > 0`, destination bits `[aw-1:aw-level]` == `addr`: bit `[aw-1-level]` selects the output; 0 → L, 1 → R.
- `level > 0`, prefix mismatch: output U.
- The legal sources for each output:
  - L output: R and U inputs.
  - R output: L and U inputs.
  - U output: L and R inputs.
- A flit whose decode names its own arrival port is a misroute. So is any flit on the U input at `level == 0`.
  - A misrouted flit is accepted (`ready_o = 1`) and dropped.
  - It never reaches an output.
  - `U` outputs at `level == 0`: `u_valid_o` is held at 0.

Arbitration, per output:
- One priority bit selects which of the two legal sources is favored.
- If both sources request, the favored source wins. If one requests, it wins.
- An output can accept when its register is empty or `ready_i` is high this cycle.
- Winner `ready_o = 1` only if the output can accept.
- On a completed input handshake, the priority bit is set to favor the *other* source.
- Reset priority:
  - L output favors R.
  - R output favors L.
  - U output favors L.
- Each input targets exactly one output, so no input is ever granted twice.

Output register:
- Loads the granted flit and sets `valid_o`.
- Holds its data stable while `valid_o && !ready_i`.
- Clears when `ready_i` is high and nothing is loaded.
- Load and drain in the same cycle gives back-to-back throughput of 1 flit/cycle/port.

Reset mid-operation: all output registers invalidate immediately, held flits are lost, and priorities return to their reset values.

## Timing
- Reset values:
  - All `*_valid_o = 0`.
  - All `*_data_o = 0`.
  - `err_cnt_o = 0`.
  - Priorities as stated under Operation.
- Latency: a flit accepted at edge N appears on `*_data_o` after edge N (1 cycle).
- `*_ready_o` depends combinationally on `*_valid_i`, `*_data_i` and `*_ready_i`.
- No path runs from `*_ready_i` to `*_valid_o`.
- Upstream holds `valid_i` and `data_i` until `ready_o`.

## Configuration
- `TSW_ERR_CNT_EN` defined:
  - `err_cnt_o` exists and increments by the number of misrouted flits accepted each cycle (0..3).
  - It saturates at 255 and is cleared only by reset.
- `TSW_ERR_CNT_EN` undefined: no port and no counter logic. Misroutes are dropped silently.

## Test plan
Test configuration: `num_leaves=8`, `level=1`, `addr=1'b0`, `payload_sz=32`.
- Routing: L input dest `3'b011` → R output after 1 cycle. R input dest `3'b000` → L output. L input dest `3'b101` → U output. U input dest `3'b010` → R output. Each payload must match its input.
- Contention: L and U both send to dest `3'b010` every cycle, with `r_ready_i=1`.
  - First grant goes to L (reset favor).
  - Grants then alternate L, U, L, U.
  - `r_valid_o` stays 1 every cycle after the first.
- Backpressure: hold `u_ready_i=0` for 5 cycles with L and R both targeting up.
  - `u_data_o` must stay stable.
  - After the first flit is captured, both `l_ready_o` and `r_ready_o` must be 0.
  - Release `u_ready_i`: flits drain one per cycle.
- Misroute: L input dest `3'b001`, U input dest `3'b110`.
  - Both are accepted the same cycle and no output goes valid.
  - With `TSW_ERR_CNT_EN`, `err_cnt_o` goes to 2. Drive 300 such cycles: `err_cnt_o` holds at 255.
- Async reset: assert `reset_n=0` mid-cycle while `l_valid_o=1`. `l_valid_o` must drop before the next clock edge. After release, R-output arbitration favors L again.
- Root: `level=0`, U input dest `3'b100`.
  - The flit is dropped.
  - `u_valid_o` stays 0 throughout.
  - An L input with dest `3'b111` reaches the R output.
